// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one 8N1 UART transmitter between four byte requesters.
// The transmitter has no ready/busy output, so frame spacing comes from a fixed-length wait counter.
module uart_tx_scheduler #(
  parameter int unsigned BAUD_DIV   = 108,
  parameter int unsigned GAP_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic [7:0]  tdata,
  output logic        tdata_req,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic        tx_done
);

  localparam int unsigned FRAME_CYCLES = 10 * (BAUD_DIV + 1) + GAP_CYCLES;
  localparam int unsigned CNT_W        = $clog2(FRAME_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       pick;
  logic [1:0]       idx;
  logic             found;

  // Round-robin pick: first pending requester after the last one granted.
  always_comb begin
    pick  = grant_id;
    idx   = grant_id;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = 2'(grant_id + 2'(i));
      if (!found && req_valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 4'b0000;
      tdata     <= 8'h00;
      tdata_req <= 1'b0;
      busy      <= 1'b0;
      grant_id  <= 2'd3;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            tdata     <= req_data[{pick, 3'b000} +: 8];
            grant_id  <= pick;
            req_ready <= 4'b0001 << pick;
            tdata_req <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          tdata_req <= 1'b0;
          req_ready <= 4'b0000;
          cnt       <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          // Window covers ten bit times plus the inter-frame gap; tdata stays held.
          if (cnt == CNT_LAST) begin
            tx_done <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
